uart_tx_arbiter: RTL and testbench

Shares the single UART transmit stream (8-bit AXI-Stream `input_axis_*` side of `uart`) among several packet sources (telemetry, debug, command echo) in the `serclk` domain. Grants one source at a time with round-robin fairness, holds the grant for a whole packet (until `tlast`), and prefixes each packet with a one-byte source-ID header so the ground side can demultiplex. A stall watchdog reclaims the link from a source that goes silent mid-packet.

---
 rtl/uart_tx_arbiter_pkg.sv | 22 ++
 rtl/uart_tx_arbiter_if.sv | 38 +++
 rtl/uart_tx_arbiter_rr_pick.sv | 32 +++
 rtl/uart_tx_arbiter.sv | 135 +++++++++++++
 tb/tb_uart_tx_arbiter.sv | 348 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_tx_arbiter_pkg.sv
// uart_arb_pkg: shared definitions for the UART transmit arbiter.
//   arb_state_e      - arbiter FSM states (idle, header byte, packet body)
//   HDR_BASE_DEFAULT - default header byte base; source id lands in bits [2:0]
//   TIMEOUT_DEFAULT  - default watchdog length in stalled body cycles
//   hdr_byte()       - builds the per-packet source-ID header byte
package uart_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_HDR,
        ARB_BODY
    } arb_state_e;

    localparam logic [7:0]  HDR_BASE_DEFAULT = 8'hA0;
    localparam int unsigned TIMEOUT_DEFAULT  = 1024;

    // Low 3 bits of base are zero, so OR-ing the id is a plain field insert.
    function automatic logic [7:0] hdr_byte(logic [7:0] base, logic [2:0] id);
        return base | {5'b00000, id};
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: bundles the N_SRC packet-source streams and the single
// byte stream towards the UART transmitter.
//   s_tdata/s_tvalid/s_tlast/s_tready - per-source AXI-Stream (byte i at [8*i+7:8*i])
//   m_tdata/m_tvalid/m_tready         - merged stream to uart.input_axis_*
// Modports:
//   slave  - the arbiter's view (sinks the sources, drives the UART side)
//   master - the environment's view (sources plus the UART ready)
interface uart_tx_arbiter_if #(
    parameter int unsigned N_SRC = 4
);
    logic [8*N_SRC-1:0] s_tdata;
    logic [N_SRC-1:0]   s_tvalid;
    logic [N_SRC-1:0]   s_tlast;
    logic [N_SRC-1:0]   s_tready;
    logic [7:0]         m_tdata;
    logic               m_tvalid;
    logic               m_tready;

    modport slave (
        input  s_tdata,
        input  s_tvalid,
        input  s_tlast,
        output s_tready,
        output m_tdata,
        output m_tvalid,
        input  m_tready
    );

    modport master (
        output s_tdata,
        output s_tvalid,
        output s_tlast,
        input  s_tready,
        input  m_tdata,
        input  m_tvalid,
        output m_tready
    );
endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// rr_pick: combinational round-robin priority encoder.
//   req   - request vector, one bit per requester
//   last  - index of the most recent winner; search starts at last+1 and wraps
//   found - at least one request is set
//   id    - winning index (0 when found is low)
module rr_pick #(
    parameter int unsigned N = 4,
    localparam int unsigned IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic          found,
    output logic [IW-1:0] id
);

    logic [IW-1:0] idx;

    always_comb begin
        found = 1'b0;
        id    = '0;
        idx   = '0;
        // The last winner is visited last (k == N), so it only wins when alone.
        for (int unsigned k = 1; k <= N; k++) begin
            idx = IW'((32'(last) + k) % N);
            if (!found && req[idx]) begin
                found = 1'b1;
                id    = idx;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares the UART transmit byte stream among N_SRC packet
// sources. Round-robin grant per packet, one header byte (HDR_BASE | id) before
// each packet, grant held until tlast, and a stall watchdog that reclaims the
// link from a source that goes silent mid-packet.
//   clk         - UART-domain clock
//   rst         - synchronous active-high reset
//   bus         - source streams and UART stream (slave modport)
//   grant_id    - current / last granted source
//   busy        - high while sending a header or packet body
//   timeout_evt - one-cycle pulse when the watchdog releases a grant
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int unsigned N_SRC    = 4,
    parameter logic [7:0]  HDR_BASE = HDR_BASE_DEFAULT,
    parameter int unsigned TIMEOUT  = TIMEOUT_DEFAULT,
    localparam int unsigned IW = $clog2(N_SRC)
) (
    input  logic                    clk,
    input  logic                    rst,
    uart_tx_arbiter_if.slave        bus,
    output logic [IW-1:0]           grant_id,
    output logic                    busy,
    output logic                    timeout_evt
);

    localparam int unsigned   WW     = $clog2(TIMEOUT);
    localparam logic [WW-1:0] WD_MAX = WW'(TIMEOUT - 1);

    arb_state_e    state_q;
    logic [7:0]    mdata_q;
    logic          mvalid_q;
    logic [IW-1:0] grant_q;
    logic [IW-1:0] last_q;
    logic [WW-1:0] wd_q;
    logic          tevt_q;

    logic          slot_free;
    logic          g_valid;
    logic          g_last;
    logic [7:0]    g_data;
    logic          pick_found;
    logic [IW-1:0] pick_id;
    logic [N_SRC-1:0] s_tready_c;

    // The output register can take a new byte when empty or being drained.
    assign slot_free = !mvalid_q || bus.m_tready;
    assign g_valid   = bus.s_tvalid[grant_q];
    assign g_last    = bus.s_tlast[grant_q];
    assign g_data    = bus.s_tdata[{grant_q, 3'b000} +: 8];

    rr_pick #(
        .N (N_SRC)
    ) u_rr_pick (
        .req   (bus.s_tvalid),
        .last  (last_q),
        .found (pick_found),
        .id    (pick_id)
    );

    // Only the granted source sees ready, and only in the body phase.
    always_comb begin
        s_tready_c = '0;
        if (state_q == ARB_BODY) begin
            s_tready_c[grant_q] = slot_free;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ARB_IDLE;
            mdata_q  <= '0;
            mvalid_q <= 1'b0;
            grant_q  <= '0;
            last_q   <= IW'(N_SRC - 1);
            wd_q     <= '0;
            tevt_q   <= 1'b0;
        end else begin
            tevt_q <= 1'b0;
            unique case (state_q)
                ARB_IDLE: begin
                    if (slot_free) begin
                        if (pick_found) begin
                            mdata_q  <= hdr_byte(HDR_BASE, 3'(pick_id));
                            mvalid_q <= 1'b1;
                            grant_q  <= pick_id;
                            last_q   <= pick_id;
                            state_q  <= ARB_HDR;
                        end else begin
                            mvalid_q <= 1'b0;
                        end
                    end
                end
                ARB_HDR: begin
                    if (bus.m_tready) begin
                        mvalid_q <= 1'b0;
                        wd_q     <= '0;
                        state_q  <= ARB_BODY;
                    end
                end
                ARB_BODY: begin
                    if (slot_free && g_valid) begin
                        mdata_q  <= g_data;
                        mvalid_q <= 1'b1;
                        wd_q     <= '0;
                        if (g_last) begin
                            state_q <= ARB_IDLE;
                        end
                    end else if (slot_free) begin
                        mvalid_q <= 1'b0;
                        // Only stalls caused by the source count, not UART backpressure.
                        if (wd_q == WD_MAX) begin
                            wd_q    <= '0;
                            tevt_q  <= 1'b1;
                            state_q <= ARB_IDLE;
                        end else begin
                            wd_q <= wd_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= ARB_IDLE;
                end
            endcase
        end
    end

    assign bus.s_tready = s_tready_c;
    assign bus.m_tdata  = mdata_q;
    assign bus.m_tvalid = mvalid_q;
    assign grant_id     = grant_q;
    assign busy         = (state_q != ARB_IDLE);
    assign timeout_evt  = tevt_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
module tb_uart_tx_arbiter;

    localparam int NS    = 4;
    localparam int TO    = 16;
    localparam int DEPTH = 1024;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_tx_arbiter_if #(.N_SRC(NS)) bus ();
    logic [1:0] grant_id;
    logic       busy;
    logic       timeout_evt;

    uart_tx_arbiter #(
        .N_SRC    (NS),
        .HDR_BASE (8'hA0),
        .TIMEOUT  (TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .grant_id    (grant_id),
        .busy        (busy),
        .timeout_evt (timeout_evt)
    );

    // Per-source byte FIFOs; bit 8 is tlast. A source is valid while non-empty.
    logic [8:0] mem [NS][DEPTH];
    int head [NS];
    int tail [NS];

    always_comb begin
        bus.s_tvalid = '0;
        bus.s_tdata  = '0;
        bus.s_tlast  = '0;
        for (int i = 0; i < NS; i++) begin
            bus.s_tvalid[i]      = (head[i] != tail[i]);
            bus.s_tdata[8*i +: 8] = mem[i][head[i] % DEPTH][7:0];
            bus.s_tlast[i]       = mem[i][head[i] % DEPTH][8];
        end
    end

    logic       mready = 1'b1;
    int         mode = 0;      // 0 ready, 1 one-on/two-off, 2 random, 3 manual
    assign bus.m_tready = mready;

    int         cyc = 0;
    logic [7:0] log_q [$];
    logic [7:0] exp_q [$];
    int         hs_edge [NS];
    int         evt_cnt = 0;
    int         evt_edge = -1;
    int         n_checks = 0;
    int         n_fail = 0;

    function automatic void check(string name, logic [31:0] got, logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, got, exp);
        end
    endfunction

    // Monitor: records accepted output bytes, source handshakes, watchdog
    // pulses, and checks that a stalled output byte stays put.
    initial begin
        logic [NS-1:0] hs;
        logic          st_pend;
        logic [7:0]    st_data;
        forever begin
            @(posedge clk);
            cyc++;
            hs = rst ? '0 : (bus.s_tvalid & bus.s_tready);
            if (!rst && bus.m_tvalid && bus.m_tready) log_q.push_back(bus.m_tdata);
            if (!rst && timeout_evt) begin
                evt_cnt++;
                evt_edge = cyc - 1;
            end
            st_pend = !rst && bus.m_tvalid && !bus.m_tready;
            st_data = bus.m_tdata;
            #1;
            for (int i = 0; i < NS; i++) begin
                if (hs[i]) begin
                    head[i]++;
                    hs_edge[i] = cyc;
                end
            end
            if (st_pend && !rst) begin
                check("stall_hold_valid", 32'(bus.m_tvalid), 32'd1);
                check("stall_hold_data", 32'(bus.m_tdata), 32'(st_data));
            end
            case (mode)
                0: mready = 1'b1;
                1: mready = (cyc % 3 == 0);
                2: mready = ($urandom_range(0, 9) < 7);
                default: ;
            endcase
        end
    end

    task automatic push_byte(int s, logic [7:0] d, logic l);
        mem[s][tail[s] % DEPTH] = {l, d};
        tail[s]++;
    endtask

    task automatic push_pkt(int s, int len, logic [7:0] base);
        for (int j = 0; j < len; j++) push_byte(s, base + 8'(j), j == len - 1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < NS; i++) head[i] = tail[i];
        repeat (2) @(negedge clk);
        rst = 1'b0;
        log_q.delete();
        evt_cnt = 0;
    endtask

    task automatic wait_done(string name, int n, int budget);
        int k;
        k = 0;
        while (k < budget && !(log_q.size() >= n && !busy && !bus.m_tvalid)) begin
            @(posedge clk);
            #2;
            k++;
        end
        if (k >= budget) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_wait: got %0d bytes after %0d cycles, required %0d and idle",
                     name, log_q.size(), budget, n);
        end
    endtask

    task automatic wait_grant(string name, logic [1:0] id);
        int k;
        k = 0;
        while (k < 20 && !(busy && grant_id == id)) begin
            @(posedge clk);
            #2;
            k++;
        end
        check({name, "_grant"}, 32'(busy && grant_id == id), 32'd1);
    endtask

    task automatic check_stream(string name);
        check({name, "_len"}, 32'(log_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            check($sformatf("%s[%0d]", name, i),
                  (i < log_q.size()) ? 32'(log_q[i]) : 32'hFFFF_FFFF, 32'(exp_q[i]));
        end
    endtask

    typedef struct {
        int         pre;    // source sending a single-byte packet first, -1 none
        logic [3:0] mask;   // sources requesting together afterwards
        int         n;      // number of packets expected
        logic [7:0] ord;    // expected grant order, 2 bits per slot, slot 0 low
    } vec_t;

    vec_t vecs [8];

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int         npk [NS];
        int         plen [NS][4];
        logic [7:0] pdat [NS][4][8];
        int         taken [NS];
        int         lastm, total, s, found;
        logic [1:0] id;

        for (int i = 0; i < NS; i++) begin
            head[i] = 0;
            tail[i] = 0;
            hs_edge[i] = 0;
        end

        vecs[0] = '{pre: -1, mask: 4'b1011, n: 3, ord: {2'd0, 2'd3, 2'd1, 2'd0}};
        vecs[1] = '{pre: -1, mask: 4'b0100, n: 1, ord: {2'd0, 2'd0, 2'd0, 2'd2}};
        vecs[2] = '{pre:  2, mask: 4'b1111, n: 4, ord: {2'd2, 2'd1, 2'd0, 2'd3}};
        vecs[3] = '{pre:  1, mask: 4'b0011, n: 2, ord: {2'd0, 2'd0, 2'd1, 2'd0}};
        vecs[4] = '{pre:  3, mask: 4'b1010, n: 2, ord: {2'd0, 2'd0, 2'd3, 2'd1}};
        vecs[5] = '{pre:  1, mask: 4'b1110, n: 3, ord: {2'd0, 2'd1, 2'd3, 2'd2}};
        vecs[6] = '{pre:  2, mask: 4'b0101, n: 2, ord: {2'd0, 2'd0, 2'd2, 2'd0}};
        vecs[7] = '{pre:  0, mask: 4'b0001, n: 1, ord: {2'd0, 2'd0, 2'd0, 2'd0}};

        // Reset state
        do_reset();
        check("rst_m_tvalid", 32'(bus.m_tvalid), 32'd0);
        check("rst_m_tdata", 32'(bus.m_tdata), 32'd0);
        check("rst_s_tready", 32'(bus.s_tready), 32'd0);
        check("rst_grant_id", 32'(grant_id), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_timeout_evt", 32'(timeout_evt), 32'd0);

        // Source 2, three bytes, header one edge after the request
        push_byte(2, 8'h11, 1'b0);
        push_byte(2, 8'h22, 1'b0);
        push_byte(2, 8'h33, 1'b1);
        @(posedge clk);
        #2;
        check("hdr_cycle1_valid", 32'(bus.m_tvalid), 32'd1);
        check("hdr_cycle1_data", 32'(bus.m_tdata), 32'hA2);
        check("hdr_cycle1_grant", 32'(grant_id), 32'd2);
        check("hdr_cycle1_busy", 32'(busy), 32'd1);
        wait_done("pkt2", 4, 40);
        exp_q = '{8'hA2, 8'h11, 8'h22, 8'h33};
        check_stream("pkt2");
        check("pkt2_busy_drop", 32'(busy), 32'd0);

        // Table: simultaneous requests after an optional priming packet
        foreach (vecs[v]) begin
            do_reset();
            if (vecs[v].pre >= 0) begin
                push_byte(vecs[v].pre, 8'hEE, 1'b1);
                wait_done($sformatf("vec%0d_pre", v), 2, 40);
                @(negedge clk);
                log_q.delete();
            end
            exp_q.delete();
            for (int k = 0; k < NS; k++) begin
                if (vecs[v].mask[k]) push_pkt(k, 2, 8'(16 * k + 1));
            end
            for (int k = 0; k < vecs[v].n; k++) begin
                id = vecs[v].ord[2*k +: 2];
                exp_q.push_back(8'hA0 | 8'(id));
                exp_q.push_back(8'(16 * id + 1));
                exp_q.push_back(8'(16 * id + 2));
            end
            wait_done($sformatf("vec%0d", v), 3 * vecs[v].n, 200);
            check_stream($sformatf("vec%0d", v));
        end

        // Backpressure one cycle on, two off
        do_reset();
        mode = 1;
        push_pkt(1, 5, 8'h40);
        wait_done("stall", 6, 200);
        exp_q = '{8'hA1, 8'h40, 8'h41, 8'h42, 8'h43, 8'h44};
        check_stream("stall");
        mode = 0;

        // Watchdog: source 1 stops after two bytes, source 0 waits
        do_reset();
        push_byte(1, 8'h51, 1'b0);
        push_byte(1, 8'h52, 1'b0);
        wait_grant("wd_src1", 2'd1);
        @(negedge clk);
        push_byte(0, 8'h01, 1'b1);
        wait_done("wd", 5, 200);
        exp_q = '{8'hA1, 8'h51, 8'h52, 8'hA0, 8'h01};
        check_stream("wd");
        check("wd_pulse_count", 32'(evt_cnt), 32'd1);
        check("wd_stall_cycles", 32'(evt_edge - hs_edge[1]), 32'(TO));

        // Fairness: source 0 keeps requesting, source 3 joins once
        do_reset();
        for (int p = 0; p < 3; p++) push_byte(0, 8'(p), 1'b1);
        wait_grant("fair_src0", 2'd0);
        @(negedge clk);
        push_byte(3, 8'h30, 1'b1);
        wait_done("fair", 8, 200);
        exp_q = '{8'hA0, 8'h00, 8'hA3, 8'h30, 8'hA0, 8'h01, 8'hA0, 8'h02};
        check_stream("fair");

        // Reset while a body byte is stuck in the output register
        do_reset();
        mode = 3;
        mready = 1'b1;
        push_pkt(2, 4, 8'h21);
        found = 0;
        for (int k = 0; k < 20 && found == 0; k++) begin
            @(posedge clk);
            #2;
            if (bus.m_tvalid && bus.m_tdata == 8'h21) found = 1;
        end
        check("rstmid_body_seen", 32'(found), 32'd1);
        mready = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #2;
        check("rstmid_m_tvalid", 32'(bus.m_tvalid), 32'd0);
        check("rstmid_busy", 32'(busy), 32'd0);
        check("rstmid_s_tready", 32'(bus.s_tready), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < NS; i++) head[i] = tail[i];
        log_q.delete();
        mode = 0;
        mready = 1'b1;
        push_byte(3, 8'h33, 1'b1);
        push_byte(0, 8'h0A, 1'b1);
        wait_done("rstmid", 4, 60);
        exp_q = '{8'hA0, 8'h0A, 8'hA3, 8'h33};
        check_stream("rstmid");

        // Random packets on all sources, random UART backpressure. Reference:
        // packets leave whole, each after its header, sources visited in
        // circular order starting from 0 and skipping sources with nothing left.
        for (int r = 0; r < 2; r++) begin
            do_reset();
            mode = 2;
            total = 0;
            for (int si = 0; si < NS; si++) begin
                npk[si] = $urandom_range(1, 3);
                taken[si] = 0;
                total += npk[si];
                for (int p = 0; p < npk[si]; p++) begin
                    plen[si][p] = $urandom_range(1, 6);
                    for (int b = 0; b < plen[si][p]; b++) begin
                        pdat[si][p][b] = 8'($urandom);
                        push_byte(si, pdat[si][p][b], b == plen[si][p] - 1);
                    end
                end
            end
            exp_q.delete();
            lastm = NS - 1;
            repeat (total) begin
                s = -1;
                for (int k = 1; k <= NS; k++) begin
                    if (s < 0 && taken[(lastm + k) % NS] < npk[(lastm + k) % NS])
                        s = (lastm + k) % NS;
                end
                exp_q.push_back(8'hA0 | 8'(s));
                for (int b = 0; b < plen[s][taken[s]]; b++) exp_q.push_back(pdat[s][taken[s]][b]);
                taken[s]++;
                lastm = s;
            end
            wait_done($sformatf("rand%0d", r), exp_q.size(), 3000);
            check_stream($sformatf("rand%0d", r));
            check($sformatf("rand%0d_no_timeout", r), 32'(evt_cnt), 32'd0);
            mode = 0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
